// File: rtl/rx_frame_arbiter_pkg.sv
// Shared types and width constants for the RX frame arbiter.
package rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned TID_W  = 3;
    localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/rx_frame_arbiter_if.sv
// Bundle of the per-port RX streams and the merged output stream.
// m_axis_tid exists only when RX_ARB_PORT_TAG_EN is defined.
interface rx_frame_arbiter_if
    import rx_arb_pkg::*;
#(
    parameter int unsigned PORTS = 4
);
    logic [PORTS*DATA_W-1:0] s_axis_tdata;
    logic [PORTS-1:0]        s_axis_tvalid;
    logic [PORTS-1:0]        s_axis_tlast;
    logic [PORTS-1:0]        s_axis_tuser;
    logic [PORTS-1:0]        s_axis_tready;

    logic [DATA_W-1:0]       m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;
    logic                    m_axis_tready;
    logic                    err_oversize;
`ifdef RX_ARB_PORT_TAG_EN
    logic [TID_W-1:0]        m_axis_tid;
`endif

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
`ifdef RX_ARB_PORT_TAG_EN
        output m_axis_tid,
`endif
        output err_oversize
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
`ifdef RX_ARB_PORT_TAG_EN
        input  m_axis_tid,
`endif
        input  err_oversize
    );

endinterface

// File: rtl/rx_frame_arbiter_rr_select.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_select #(
    parameter int unsigned PORTS = 4,
    parameter int unsigned IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    idx,
    output logic             found
);

    always_comb begin
        int unsigned c;
        c     = 0;
        idx   = '0;
        found = 1'b0;
        // Walk distances from farthest to nearest so the nearest requester wins.
        for (int unsigned k = PORTS; k >= 1; k--) begin
            c = (32'(last_grant) + k) % PORTS;
            if (req[c[IW-1:0]]) begin
                idx   = c[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_frame_arbiter.sv
// Round-robin merge of PORTS RX frame streams with MAX_LEN truncation and drain.
// Optional RX_ARB_PORT_TAG_EN adds m_axis_tid carrying the granted port.
module rx_frame_arbiter
    import rx_arb_pkg::*;
#(
    parameter int unsigned PORTS   = 4,
    parameter int unsigned MAX_LEN = 1522
) (
    input logic              clk,
    input logic              rst_n,
    rx_frame_arbiter_if.master bus
);

    localparam int unsigned IW = $clog2(PORTS);

    arb_state_t       state;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    sel_idx;
    logic             sel_found;
    logic [CNT_W-1:0] beat_cnt;
    logic             err_q;

    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_last;
    logic              src_user;
    logic              at_max;

    rr_select #(.PORTS(PORTS), .IW(IW)) u_rr_select (
        .req        (bus.s_axis_tvalid),
        .last_grant (last_grant),
        .idx        (sel_idx),
        .found      (sel_found)
    );

    assign src_data  = bus.s_axis_tdata[grant*DATA_W +: DATA_W];
    assign src_valid = bus.s_axis_tvalid[grant];
    assign src_last  = bus.s_axis_tlast[grant];
    assign src_user  = bus.s_axis_tuser[grant];
    // Current beat would be number MAX_LEN of the frame.
    assign at_max    = (beat_cnt == CNT_W'(MAX_LEN - 1));

    assign bus.err_oversize = err_q;

    always_comb begin
        bus.s_axis_tready = '0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tuser  = 1'b0;
`ifdef RX_ARB_PORT_TAG_EN
        bus.m_axis_tid    = '0;
`endif
        case (state)
            PASS: begin
                bus.m_axis_tdata         = src_data;
                bus.m_axis_tvalid        = src_valid;
                bus.m_axis_tlast         = src_last | at_max;
                bus.m_axis_tuser         = src_user | (at_max & ~src_last);
                bus.s_axis_tready[grant] = bus.m_axis_tready;
`ifdef RX_ARB_PORT_TAG_EN
                bus.m_axis_tid           = TID_W'(grant);
`endif
            end
            DRAIN: bus.s_axis_tready[grant] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(PORTS - 1);
            beat_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant    <= sel_idx;
                        beat_cnt <= '0;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (src_valid && bus.m_axis_tready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (src_last) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end else if (at_max) begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (src_valid && src_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Randomized self-checking bench for rx_frame_arbiter against a frame-level model.
module tb_rx_frame_arbiter;
    localparam int PORTS   = 4;
    localparam int MAX_LEN = 1522;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_frame_arbiter_if #(.PORTS(PORTS)) bus ();

    rx_frame_arbiter #(.PORTS(PORTS), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Source side: flattened beats per port plus frame lengths for the model.
    logic [7:0] sq_data [PORTS][$];
    logic       sq_last [PORTS][$];
    logic       sq_user [PORTS][$];
    int         fq_len  [PORTS][$];
    logic       mid     [PORTS];

    // Expected merged output, in order.
    logic [7:0] ex_data [$];
    logic       ex_last [$];
    logic       ex_user [$];
    logic       ex_trunc[$];
    int         ex_port [$];

    int exp_drain, drained, model_lg, beats_out, gap_pct;
    logic [PORTS-1:0] hs_mask;
    logic err_exp, gap_exp;
    bit   rand_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int p, input int len, input logic user_last);
        for (int i = 0; i < len; i++) begin
            sq_data[p].push_back(8'($urandom));
            sq_last[p].push_back(i == len - 1);
            sq_user[p].push_back((i == len - 1) ? user_last : 1'b0);
        end
        fq_len[p].push_back(len);
    endtask

    // Replays the queued frames in round-robin order and applies the truncation rule.
    task automatic build_expected();
        int lens [PORTS][$];
        int pos  [PORTS];
        int c, len;
        bit found, trunc;
        for (int p = 0; p < PORTS; p++) begin
            lens[p] = fq_len[p];
            fq_len[p].delete();
            pos[p] = 0;
        end
        forever begin
            found = 0;
            c = 0;
            for (int k = 1; k <= PORTS; k++) begin
                if (!found && lens[(model_lg + k) % PORTS].size() > 0) begin
                    c = (model_lg + k) % PORTS;
                    found = 1;
                end
            end
            if (!found) break;
            len = lens[c].pop_front();
            for (int i = 0; i < len; i++) begin
                if (i < MAX_LEN) begin
                    trunc = (i == MAX_LEN - 1) && (len > MAX_LEN);
                    ex_data.push_back(sq_data[c][pos[c]]);
                    ex_last.push_back(sq_last[c][pos[c]] | trunc);
                    ex_user.push_back(sq_user[c][pos[c]] | trunc);
                    ex_trunc.push_back(trunc);
                    ex_port.push_back(c);
                end else begin
                    exp_drain++;
                end
                pos[c]++;
            end
            model_lg = c;
        end
    endtask

    task automatic sample();
        logic [PORTS-1:0] hs;
        int port;
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        port = -1;
        for (int p = 0; p < PORTS; p++) if (hs[p]) port = p;
        check("single_ready", 32'($countones(bus.s_axis_tready) <= 1), 1);
        check("err_oversize", bus.err_oversize, err_exp);
        err_exp = 1'b0;
        if (gap_exp) check("frame_gap", bus.m_axis_tvalid, 0);
        gap_exp = 1'b0;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (ex_data.size() == 0) begin
                check("unexpected_beat", ex_data.size(), 1);
            end else begin
                check("tdata", bus.m_axis_tdata, ex_data.pop_front());
                check("tlast", bus.m_axis_tlast, ex_last[0]);
                check("tuser", bus.m_axis_tuser, ex_user.pop_front());
                check("src_port", port, ex_port[0]);
`ifdef RX_ARB_PORT_TAG_EN
                check("tid", bus.m_axis_tid, ex_port[0]);
`endif
                gap_exp = ex_last.pop_front();
                err_exp = ex_trunc.pop_front();
                void'(ex_port.pop_front());
                beats_out++;
            end
        end else if (hs != '0) begin
            drained++;
        end
        hs_mask = hs;
    endtask

    task automatic drive();
        logic vld;
        for (int p = 0; p < PORTS; p++) begin
            if (hs_mask[p] && sq_data[p].size() > 0) begin
                mid[p] = !sq_last[p][0];
                void'(sq_data[p].pop_front());
                void'(sq_last[p].pop_front());
                void'(sq_user[p].pop_front());
            end
            vld = (sq_data[p].size() > 0) && !(mid[p] && ($urandom_range(99) < gap_pct));
            bus.s_axis_tvalid[p]         = vld;
            bus.s_axis_tdata[p*8 +: 8]   = (sq_data[p].size() > 0) ? sq_data[p][0] : 8'h00;
            bus.s_axis_tlast[p]          = (sq_last[p].size() > 0) ? sq_last[p][0] : 1'b0;
            bus.s_axis_tuser[p]          = (sq_user[p].size() > 0) ? sq_user[p][0] : 1'b0;
        end
        bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        hs_mask = '0;
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < PORTS; p++) if (sq_data[p].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_phase(input int budget, input int stop_after);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 0;
        drive();
        while (cyc < budget) begin
            @(negedge clk);
            sample();
            cyc++;
            if (stop_after > 0 && beats_out >= stop_after) return;
            done = all_empty() && (ex_data.size() == 0);
            if (done) break;
            @(posedge clk);
            #1;
            drive();
        end
        check("phase_budget", done, 1);
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
        check("drained_beats", drained, exp_drain);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            sq_data[p].delete();
            sq_last[p].delete();
            sq_user[p].delete();
            fq_len[p].delete();
            mid[p] = 1'b0;
        end
        ex_data.delete(); ex_last.delete(); ex_user.delete(); ex_trunc.delete(); ex_port.delete();
        model_lg  = PORTS - 1;
        exp_drain = 0;
        drained   = 0;
        beats_out = 0;
        err_exp   = 1'b0;
        gap_exp   = 1'b0;
        hs_mask   = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rand_ready = 0;
        gap_pct    = 0;
        rst_n      = 1'b0;
        bus.s_axis_tvalid = '1;
        bus.s_axis_tdata  = '1;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        #2;
        check("rst_s_tready", bus.s_axis_tready, 0);
        check("rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("rst_err", bus.err_oversize, 0);
        do_reset();

        // Single 64-beat frame on port 2.
        add_frame(2, 64, 1'b0);
        build_expected();
        run_phase(2000, 0);

        // Ports 0, 1, 3 contending with two 10-beat frames each.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            add_frame(0, 10, 1'b0);
            add_frame(1, 10, 1'b0);
            add_frame(3, 10, 1'b0);
        end
        build_expected();
        run_phase(500, 0);

        // Oversize frame, then a frame of exactly MAX_LEN beats with tuser on last.
        add_frame(1, 1600, 1'b0);
        build_expected();
        run_phase(4000, 0);
        add_frame(3, MAX_LEN, 1'b1);
        build_expected();
        run_phase(4000, 0);

        // Random backpressure, random mid-frame valid gaps and random frames.
        rand_ready = 1;
        gap_pct    = 20;
        add_frame(2, 5, 1'b1);
        for (int n = 0; n < 12; n++)
            add_frame($urandom_range(0, PORTS - 1), $urandom_range(1, 40), 1'($urandom_range(0, 1)));
        build_expected();
        run_phase(6000, 0);

        // Reset after 30 beats of a frame on port 2.
        rand_ready = 0;
        gap_pct    = 0;
        do_reset();
        add_frame(2, 60, 1'b0);
        build_expected();
        run_phase(500, 30);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("mid_rst_m_tlast", bus.m_axis_tlast, 0);
        check("mid_rst_m_tuser", bus.m_axis_tuser, 0);
        check("mid_rst_m_tdata", bus.m_axis_tdata, 0);
        check("mid_rst_s_tready", bus.s_axis_tready, 0);
        check("mid_rst_err", bus.err_oversize, 0);
        do_reset();
        add_frame(1, 8, 1'b0);
        add_frame(0, 8, 1'b0);
        build_expected();
        run_phase(500, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
